// File: rtl/tdc_pkg.sv
// Shared constants, event-word layout and pairing FSM state type
// for the TDC time-over-threshold readout stages.
package tdc_pkg;

    localparam int FINE_BINS   = 110;
    localparam int COARSE_BINS = 32;
    localparam int CODE_PERIOD = FINE_BINS * COARSE_BINS;

    // Event word layout: {code_err, orphan, toa[11:0], tot[11:0]}
    localparam int TOT_LSB    = 0;
    localparam int TOA_LSB    = 12;
    localparam int ORPHAN_BIT = 24;
    localparam int ERR_BIT    = 25;
    localparam int EVENT_W    = 26;

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        WAIT_TRAIL = 1'b1
    } pair_state_t;

endpackage

// File: rtl/tdc_sync_fifo.sv
// Synchronous first-word fall-through FIFO with occupancy count.
// A pop on a full FIFO frees the slot a same-cycle push needs.
module tdc_sync_fifo #(
    parameter  int WIDTH = 26,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    // Empty FIFO presents zero so the head never shows stale storage.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/tdc_tot_buffer.sv
// Pairs leading/trailing TDC codes into TOA/TOT events, flags orphan
// edges and out-of-range codes, and buffers events for readout.
module tdc_tot_buffer #(
    parameter int CODE_W      = 12,
    parameter int CODE_PERIOD = tdc_pkg::CODE_PERIOD,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        lead_valid,
    input  logic [CODE_W-1:0]           lead_code,
    input  logic                        trail_valid,
    input  logic [CODE_W-1:0]           trail_code,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [tdc_pkg::EVENT_W-1:0] out_data,
    output logic [3:0]                  fifo_count,
    output logic [7:0]                  drop_cnt,
    output logic [7:0]                  stray_cnt
);

    import tdc_pkg::*;

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [CODE_W-1:0]        PERIOD_U = CODE_W'(CODE_PERIOD);
    localparam logic signed [CODE_W:0]   PERIOD_S = (CODE_W+1)'(CODE_PERIOD);
    localparam logic [TMR_W-1:0]         TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    // Trail minus lead, folded back into one TDC period.
    function automatic logic [CODE_W-1:0] wrap_tot(input logic [CODE_W-1:0] trail,
                                                   input logic [CODE_W-1:0] lead);
        logic signed [CODE_W:0] diff;
        logic signed [CODE_W:0] folded;
        diff   = $signed({1'b0, trail}) - $signed({1'b0, lead});
        folded = (diff < 0) ? diff + PERIOD_S : diff;
        return folded[CODE_W-1:0];
    endfunction

    // Event counters stick at full scale rather than wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    pair_state_t          state;
    pair_state_t          state_nxt;
    logic [TMR_W-1:0]     timer;
    logic [CODE_W-1:0]    toa_reg;

    logic                 latch_lead;
    logic                 timer_clr;
    logic                 timer_inc;
    logic                 close_ev;
    logic                 close_orphan;
    logic                 stray;

    logic                 lead_err;
    logic                 trail_err;
    logic [EVENT_W-1:0]   ev_word;
    logic [EVENT_W-1:0]   ev_p1;
    logic                 vld_p1;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 drop;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Pairing decisions: which edge opens, closes or is discarded this cycle.
    always_comb begin
        state_nxt    = state;
        latch_lead   = 1'b0;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;
        close_ev     = 1'b0;
        close_orphan = 1'b0;
        stray        = 1'b0;
        case (state)
            IDLE: begin
                if (trail_valid) stray = 1'b1;
                if (lead_valid) begin
                    latch_lead = 1'b1;
                    timer_clr  = 1'b1;
                    state_nxt  = WAIT_TRAIL;
                end
            end
            WAIT_TRAIL: begin
                if (trail_valid) begin
                    close_ev = 1'b1;
                    if (lead_valid) begin
                        latch_lead = 1'b1;
                        timer_clr  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (lead_valid) begin
                    close_ev     = 1'b1;
                    close_orphan = 1'b1;
                    latch_lead   = 1'b1;
                    timer_clr    = 1'b1;
                end else if (timer == TMR_LAST) begin
                    close_ev     = 1'b1;
                    close_orphan = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Trailing-edge timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         timer <= '0;
        else if (timer_clr) timer <= '0;
        else if (timer_inc) timer <= timer + TMR_W'(1);
    end

    // Open event's leading code.
    always_ff @(posedge clk) begin
        if (latch_lead) toa_reg <= lead_code;
    end

    assign lead_err  = (toa_reg >= PERIOD_U);
    assign trail_err = (trail_code >= PERIOD_U);

    // Event word for whatever closes this cycle.
    always_comb begin
        ev_word = '0;
        ev_word[TOA_LSB +: CODE_W] = toa_reg;
        ev_word[ORPHAN_BIT]        = close_orphan;
        if (close_orphan) begin
            ev_word[ERR_BIT] = lead_err;
        end else begin
            ev_word[ERR_BIT] = lead_err || trail_err;
            if (!(lead_err || trail_err)) begin
                ev_word[TOT_LSB +: CODE_W] = wrap_tot(trail_code, toa_reg);
            end
        end
    end

    // ---- stage p1: registered event word heading into the FIFO ----
    always_ff @(posedge clk) begin
        if (close_ev) ev_p1 <= ev_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= close_ev;
    end

    tdc_sync_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_p1),
        .wdata (ev_p1),
        .pop   (out_ready),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign drop      = vld_p1 && fifo_full && !(out_valid && out_ready);

    // Drop and stray event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt  <= '0;
            stray_cnt <= '0;
        end else begin
            if (drop)  drop_cnt  <= sat_inc(drop_cnt);
            if (stray) stray_cnt <= sat_inc(stray_cnt);
        end
    end

endmodule

// File: tb/tb_tdc_tot_buffer.sv
// Scoreboard bench for tdc_tot_buffer: expected events are queued as
// stimulus is issued; a monitor pops and compares on each handshake.
module tb_tdc_tot_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lead_valid;
    logic [11:0] lead_code;
    logic        trail_valid;
    logic [11:0] trail_code;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_data;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_cnt;
    logic [7:0]  stray_cnt;

    int tests = 0;
    int fails = 0;
    logic [25:0] exp_q[$];

    tdc_tot_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lead_valid  (lead_valid),
        .lead_code   (lead_code),
        .trail_valid (trail_valid),
        .trail_code  (trail_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .fifo_count  (fifo_count),
        .drop_cnt    (drop_cnt),
        .stray_cnt   (stray_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] ev(input bit err, input bit orph,
                                       input int toa, input int tot);
        logic [11:0] a;
        logic [11:0] t;
        a = 12'(toa);
        t = 12'(tot);
        return {err, orph, a, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit lv, input int lc, input bit tv, input int tc);
        lead_valid  = lv;
        lead_code   = 12'(lc);
        trail_valid = tv;
        trail_code  = 12'(tc);
        tick();
        lead_valid  = 1'b0;
        trail_valid = 1'b0;
    endtask

    // Normal lead/trail pair one cycle apart, with its expected word queued.
    task automatic pair(input int lc, input int tc, input logic [25:0] exp);
        exp_q.push_back(exp);
        drive(1, lc, 0, 0);
        drive(0, 0, 1, tc);
        tick();
    endtask

    // Monitor: compare each accepted head against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got 0x%0h, expected no event", out_data);
                end else begin
                    logic [25:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        fails++;
                        $display("FAIL event: got err=%0b orph=%0b toa=%0d tot=%0d, expected err=%0b orph=%0b toa=%0d tot=%0d",
                                 out_data[25], out_data[24], out_data[23:12], out_data[11:0],
                                 e[25], e[24], e[23:12], e[11:0]);
                    end
                end
            end
        end
    end

    initial begin
        bit done;
        rst_n       = 1'b0;
        lead_valid  = 1'b0;
        lead_code   = '0;
        trail_valid = 1'b0;
        trail_code  = '0;
        out_ready   = 1'b1;
        repeat (3) tick();

        check("rst_out_valid",  32'(out_valid),  0);
        check("rst_out_data",   32'(out_data),   0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_drop_cnt",   32'(drop_cnt),   0);
        check("rst_stray_cnt",  32'(stray_cnt),  0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic event and its latency: visible two edges after the trail.
        exp_q.push_back(ev(0, 0, 100, 1100));
        drive(1, 100, 0, 0);
        repeat (4) tick();
        drive(0, 0, 1, 1200);
        check("lat_not_yet", 32'(out_valid), 0);
        tick();
        check("lat_valid", 32'(out_valid), 1);
        repeat (2) tick();

        // Period wrap and equal codes.
        pair(3500, 20,   ev(0, 0, 3500, 40));
        pair(0,    3519, ev(0, 0, 0, 3519));
        pair(777,  777,  ev(0, 0, 777, 0));

        // Lead preempted by a second lead, then a normal trail.
        exp_q.push_back(ev(0, 1, 50, 0));
        exp_q.push_back(ev(0, 0, 60, 30));
        drive(1, 50, 0, 0);
        drive(1, 60, 0, 0);
        drive(0, 0, 1, 90);
        repeat (3) tick();

        // Trailing-edge timeout.
        exp_q.push_back(ev(0, 1, 200, 0));
        drive(1, 200, 0, 0);
        repeat (70) tick();
        check("timeout_drained", 32'(exp_q.size()), 0);

        // Stray trail in IDLE.
        drive(0, 0, 1, 500);
        repeat (3) tick();
        check("stray_cnt_1",   32'(stray_cnt),  1);
        check("stray_fifo",    32'(fifo_count), 0);

        // Out-of-range leading code.
        pair(3600, 100, ev(1, 0, 3600, 0));

        // Simultaneous edges while waiting: trail closes, lead reopens.
        exp_q.push_back(ev(0, 0, 10, 390));
        exp_q.push_back(ev(0, 0, 300, 200));
        drive(1, 10, 0, 0);
        drive(1, 300, 1, 400);
        drive(0, 0, 1, 500);
        repeat (3) tick();

        // Simultaneous edges in IDLE: lead opens, trail is stray.
        exp_q.push_back(ev(0, 0, 1000, 100));
        drive(1, 1000, 1, 5);
        drive(0, 0, 1, 1100);
        repeat (3) tick();
        check("stray_cnt_2", 32'(stray_cnt), 2);

        // Backpressure: ten events into an eight-deep FIFO.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_q.push_back(ev(0, 0, i * 10, 7));
            drive(1, i * 10, 0, 0);
            drive(0, 0, 1, i * 10 + 7);
        end
        repeat (3) tick();
        check("bp_fifo_count", 32'(fifo_count), 8);
        check("bp_drop_cnt",   32'(drop_cnt),   2);
        check("bp_head_a",     32'(out_data),   32'(ev(0, 0, 0, 7)));
        repeat (4) tick();
        check("bp_head_b",     32'(out_data),   32'(ev(0, 0, 0, 7)));
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (fifo_count == 0) done = 1'b1;
        end
        check("bp_drain_done", 32'(done), 1);
        check("bp_all_seen",   32'(exp_q.size()), 0);

        // Reset while an event is open and three entries are queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 400 + i, 0, 0);
            drive(0, 0, 1, 450 + i);
        end
        drive(1, 2000, 0, 0);
        tick();
        check("pre_rst_count", 32'(fifo_count), 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid",  32'(out_valid),  0);
        check("async_fifo_count", 32'(fifo_count), 0);
        check("async_drop_cnt",   32'(drop_cnt),   0);
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        drive(0, 0, 1, 50);
        repeat (3) tick();
        check("post_rst_stray", 32'(stray_cnt),  1);
        check("post_rst_fifo",  32'(fifo_count), 0);
        check("final_queue",    32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdc_tot_buffer.md
Name: tdc_tot_buffer

Overview:
- Downstream consumer of TDC_encoder.
- Takes the 12-bit TDC codes for a hit's leading and trailing edges, on separate valid strobes, and pairs them into events: TOA = leading code, TOT = trailing minus leading, modulo the TDC period.
- Buffers completed events in a small FIFO with a valid/ready readout to the chip's data-formatting logic.
- Flags orphan edges and out-of-range codes.

Parameters:
- CODE_W, 12, width of TDC code, TOA and TOT fields
- CODE_PERIOD, 3520, TDC full-scale period in LSBs (32 coarse x 110 fine bins); legal codes are 0..3519
- FIFO_DEPTH, 8, event FIFO depth in entries (power of 2)
- TIMEOUT_CYC, 64, clk cycles to wait for a trailing edge before closing the event as orphan

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lead_valid  in  1  one-cycle strobe: lead_code holds a leading-edge TDC code
- lead_code  in  12  leading-edge TDC_bin_code
- trail_valid  in  1  one-cycle strobe: trail_code holds a trailing-edge TDC code
- trail_code  in  12  trailing-edge TDC_bin_code
- out_valid  out  1  FIFO head holds an event
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- out_data  out  26  {code_err, orphan, toa[11:0], tot[11:0]}
- fifo_count  out  4  entries currently stored (0..FIFO_DEPTH)
- drop_cnt  out  8  events lost to FIFO full; saturates at 255
- stray_cnt  out  8  trailing edges with no open event; saturates at 255

Behaviour:
- Reset:
  - Asynchronous, active-low; all state clears immediately, including mid-event.
  - Outputs after reset: out_valid=0, out_data=0, fifo_count=0, drop_cnt=0, stray_cnt=0. FSM goes to IDLE.
- FSM states: IDLE, WAIT_TRAIL.
  - IDLE + lead_valid: latch lead_code into toa_reg, clear timer, go to WAIT_TRAIL.
  - IDLE + trail_valid alone: stray_cnt++, nothing pushed.
  - IDLE + lead_valid & trail_valid in the same cycle: the lead is taken as above; the trail is treated as stray (stray_cnt++).
  - WAIT_TRAIL + trail_valid: compute the event with orphan=0, go to IDLE.
  - WAIT_TRAIL + lead_valid alone: close the open event as orphan (tot=0, orphan=1), latch the new lead, stay in WAIT_TRAIL, clear timer.
  - WAIT_TRAIL + lead_valid & trail_valid in the same cycle: the trail closes the current event normally; the new lead opens the next event; stay in WAIT_TRAIL.
  - WAIT_TRAIL, timer reaches TIMEOUT_CYC-1 with no edge: close as orphan, go to IDLE.
- TOT arithmetic:
  - diff = trail_code - toa_reg, computed at 13 bits signed.
  - tot = diff if diff >= 0, else diff + CODE_PERIOD. Result is always 0..3519.
  - Equal codes give tot=0. Example: lead 3500, trail 20 gives tot=40.
- code_err:
  - Set when either edge code is >= CODE_PERIOD.
  - With code_err set: tot forced to 0, toa carries the raw leading code, and the event is still pushed.
- Pipeline and latency:
  - The closing edge at cycle N registers the event word at N+1.
  - FIFO write happens at the N+1 edge; out_valid is seen at N+2 when the FIFO was empty.
  - At most one event closes per cycle.
- FIFO:
  - Synchronous, first-word fall-through; out_data is stable while out_valid & !out_ready.
  - Write with FIFO full: the event is discarded and drop_cnt increments (saturating).
  - Simultaneous push and pop when full: the pop frees space, so the push succeeds and no drop is counted.
  - Simultaneous push and pop when empty: the new word appears next cycle.
  - fifo_count updates the cycle after each push/pop.
- Counter saturation: drop_cnt and stray_cnt hold at 255.

Decomposition:
- Package tdc_pkg holds:
  - constants FINE_BINS=110, COARSE_BINS=32, CODE_PERIOD=3520;
  - out_data field positions (TOT_LSB=0, TOA_LSB=12, ORPHAN_BIT=24, ERR_BIT=25);
  - the FSM state enum.
- Sub-module tdc_sync_fifo:
  - parameterised width and depth;
  - provides push/pop/full/empty/count;
  - reusable by other readout stages.
- Pairing FSM, TOT arithmetic and counters stay in tdc_tot_buffer.

Test Plan:
- Basic event: lead 100 at cycle 0, trail 1200 at cycle 5, out_ready=1 -> out_valid at cycle 7 with toa=100, tot=1100, orphan=0, code_err=0.
- Wrap-around: lead 3500, trail 20 -> tot=40; lead 0, trail 3519 -> tot=3519; lead=trail=777 -> tot=0.
- Orphans:
  - lead 50 then lead 60 with no trail -> first event {orphan=1, toa=50, tot=0}; then trail 90 -> {toa=60, tot=30}.
  - lead with no trail for 64 cycles -> orphan event pushed.
  - trail in IDLE -> stray_cnt=1, FIFO untouched.
- Range error: lead 3600, trail 100 -> code_err=1, toa=3600, tot=0.
- Backpressure: out_ready=0, push 10 events -> fifo_count=8, drop_cnt=2; drain with out_ready=1 -> 8 events in order, head stable while stalled.
- Reset mid-event: assert rst_n low in WAIT_TRAIL with 3 entries queued -> out_valid=0 and fifo_count=0 at once; a trail after release counts as stray.
